instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 165 ++++++++++++++++
 tb/tb_instr_encoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction-word encoder: packs field beats into 32-bit words, queues them in a
// 2-entry FIFO and streams them to a word-addressed memory. Option macro: INSTR_ENCODER_ILLEGAL_OP_CHECK_EN.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  cond,
    input  logic [1:0]  op,
    input  logic [5:0]  funct,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [11:0] src2,
    input  logic [23:0] imm24,
    input  logic        in_last,
    output logic        mem_we,
    input  logic        mem_gnt,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [8:0]  count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] fifo_r [2];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  fcnt_r;
    logic [7:0]  addr_r;
    logic [8:0]  count_r;
    logic        err_r;

    logic        accept_s;
    logic        illegal_s;
    logic        push_s;
    logic        pop_s;
    logic        ovf_s;
    logic [31:0] word_s;

    // Branches carry a 24-bit immediate in place of the register/operand fields.
    function automatic logic [31:0] encode(
        input logic [3:0]  f_cond,
        input logic [1:0]  f_op,
        input logic [5:0]  f_funct,
        input logic [3:0]  f_rn,
        input logic [3:0]  f_rd,
        input logic [11:0] f_src2,
        input logic [23:0] f_imm24
    );
        logic [31:0] w;
        if (f_op == 2'b10) begin
            w = {f_cond, f_op, f_funct[5:4], f_imm24};
        end else begin
            w = {f_cond, f_op, f_funct, f_rn, f_rd, f_src2};
        end
        return w;
    endfunction

`ifdef INSTR_ENCODER_ILLEGAL_OP_CHECK_EN
    assign illegal_s = (op == 2'b11);
`else
    assign illegal_s = 1'b0;
`endif

    assign in_ready  = (state_r == LOAD) && (fcnt_r != 2'd2);
    assign mem_we    = (fcnt_r != 2'd0);
    assign mem_wdata = mem_we ? fifo_r[rd_ptr_r] : 32'd0;
    assign mem_addr  = addr_r;
    assign count     = count_r;
    assign err       = err_r;
    assign busy      = (state_r == LOAD) || (state_r == FLUSH);
    assign done      = (state_r == DONE);

    // Datapath strobes derived from the handshakes.
    always_comb begin
        word_s   = encode(cond, op, funct, rn, rd, src2, imm24);
        accept_s = in_valid && in_ready;
        pop_s    = mem_we && mem_gnt;
        ovf_s    = pop_s && (addr_r == 8'd255);
        push_s   = accept_s && !illegal_s && !ovf_s;
    end

    // Control FSM together with FIFO, address, counter and error state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            fifo_r[0] <= 32'd0;
            fifo_r[1] <= 32'd0;
            rd_ptr_r  <= 1'b0;
            wr_ptr_r  <= 1'b0;
            fcnt_r    <= 2'd0;
            addr_r    <= 8'd0;
            count_r   <= 9'd0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r  <= LOAD;
                        rd_ptr_r <= 1'b0;
                        wr_ptr_r <= 1'b0;
                        fcnt_r   <= 2'd0;
                        addr_r   <= 8'd0;
                        count_r  <= 9'd0;
                        err_r    <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                LOAD, FLUSH: begin
                    if (ovf_s) begin
                        // Address space exhausted: drop everything queued and stop.
                        state_r  <= DONE;
                        err_r    <= 1'b1;
                        rd_ptr_r <= 1'b0;
                        wr_ptr_r <= 1'b0;
                        fcnt_r   <= 2'd0;
                        addr_r   <= 8'd0;
                        count_r  <= count_r + 9'd1;
                    end else begin
                        if (push_s) begin
                            fifo_r[wr_ptr_r] <= word_s;
                            wr_ptr_r         <= ~wr_ptr_r;
                        end
                        if (pop_s) begin
                            rd_ptr_r <= ~rd_ptr_r;
                            addr_r   <= addr_r + 8'd1;
                            count_r  <= count_r + 9'd1;
                        end
                        case ({push_s, pop_s})
                            2'b10:   fcnt_r <= fcnt_r + 2'd1;
                            2'b01:   fcnt_r <= fcnt_r - 2'd1;
                            default: fcnt_r <= fcnt_r;
                        endcase
                        if (accept_s && illegal_s) begin
                            err_r <= 1'b1;
                        end
                        if ((state_r == LOAD) && accept_s && in_last) begin
                            state_r <= FLUSH;
                        end else if ((state_r == FLUSH) && (fcnt_r == 2'd0)) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    fcnt_r  <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder with a queue-based reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  cond = 4'd0;
    logic [1:0]  op = 2'd0;
    logic [5:0]  funct = 6'd0;
    logic [3:0]  rn = 4'd0;
    logic [3:0]  rd = 4'd0;
    logic [11:0] src2 = 12'd0;
    logic [23:0] imm24 = 24'd0;
    logic        in_last = 1'b0;
    logic        mem_we;
    logic        mem_gnt = 1'b0;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  count;

`ifdef INSTR_ENCODER_ILLEGAL_OP_CHECK_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    bit          gnt_rand = 1'b0;
    bit          gnt_val = 1'b0;
    logic [31:0] expq[$];
    logic [31:0] wlog[$];
    int          exp_addr = 0;
    int          writes = 0;

    instr_encoder dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .op(op), .funct(funct), .rn(rn), .rd(rd), .src2(src2),
        .imm24(imm24), .in_last(in_last), .mem_we(mem_we), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Field weights taken straight from the word layout.
    function automatic logic [31:0] ref_word(input int c, input int o, input int f,
                                             input int n, input int d, input int s, input int i);
        int unsigned w;
        if (o == 2) w = c * (1 << 28) + o * (1 << 26) + (f / 16) * (1 << 24) + i;
        else        w = c * (1 << 28) + o * (1 << 26) + f * (1 << 20) + n * (1 << 16) + d * (1 << 12) + s;
        return w;
    endfunction

    always @(posedge clk) begin
        #1 mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_val;
    end

    // Reference model and output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        bit ovf;
        ovf = 1'b0;
        if (mon_en) begin
            chk("mem_we", mem_we, expq.size() != 0);
            if (mem_we && expq.size() != 0) begin
                chk("wdata", mem_wdata, expq[0]);
                chk("addr", mem_addr, exp_addr);
                if (mem_gnt) begin
                    wlog.push_back(mem_wdata);
                    writes++;
                    void'(expq.pop_front());
                    if (exp_addr == 255) begin
                        ovf = 1'b1;
                        expq.delete();
                        exp_addr = 0;
                    end else begin
                        exp_addr++;
                    end
                end
            end
            if (in_valid && in_ready && !ovf && !(ILL && op == 2'b11))
                expq.push_back(ref_word(cond, op, funct, rn, rd, src2, imm24));
        end
    end

    task automatic pulse_start();
        exp_addr = 0;
        writes = 0;
        wlog.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic set_beat(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] n, input logic [3:0] d, input logic [11:0] s,
                            input logic [23:0] i, input logic l);
        cond = c; op = o; funct = f; rn = n; rd = d; src2 = s; imm24 = i; in_last = l;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept(input int limit);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < limit) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                        input logic [3:0] n, input logic [3:0] d, input logic [11:0] s,
                        input logic [23:0] i, input logic l);
        set_beat(c, o, f, n, d, s, i, l);
        wait_accept(200);
    endtask

    task automatic send_rand(input logic [1:0] o, input logic l);
        send(4'($urandom), o, 6'($urandom), 4'($urandom), 4'($urandom), 12'($urandom),
             24'($urandom), l);
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < limit) begin
            k++;
            @(negedge clk);
        end
        chk("done_wait", done, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int npush;
        bit any_ill;
        logic [1:0] o;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 8'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_count", count, 9'd0);
        rst = 1'b1;
        mon_en = 1'b1;
        gnt_val = 1'b1;
        @(posedge clk); #1;

        // Single ALU word
        pulse_start();
        chk("load_busy", busy, 1'b1);
        send(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'd0, 1'b1);
        wait_done(50);
        chk("add_word", wlog.size() > 0 ? wlog[0] : 32'hx, 32'hE2821005);
        chk("add_count", count, 9'd1);
        chk("add_busy", busy, 1'b0);

        // Branch then store
        pulse_start();
        send(4'hE, 2'b10, 6'b100000, 4'd0, 4'd0, 12'd0, 24'h000003, 1'b0);
        send(4'hE, 2'b01, 6'b011000, 4'd0, 4'd3, 12'h004, 24'd0, 1'b1);
        wait_done(50);
        chk("br_word", wlog.size() > 0 ? wlog[0] : 32'hx, 32'hEA000003);
        chk("st_word", wlog.size() > 1 ? wlog[1] : 32'hx, 32'hE5803004);
        chk("bs_count", count, 9'd2);

        // Backpressure, with a stray start that must be ignored
        gnt_val = 1'b0;
        @(posedge clk); #1;
        pulse_start();
        send(4'h1, 2'b00, 6'h01, 4'd1, 4'd1, 12'h111, 24'd0, 1'b0);
        start = 1'b1;
        send(4'h2, 2'b00, 6'h02, 4'd2, 4'd2, 12'h222, 24'd0, 1'b0);
        start = 1'b0;
        set_beat(4'h3, 2'b00, 6'h03, 4'd3, 4'd3, 12'h333, 24'd0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_wdata", mem_wdata, 32'h10111111);
        end
        @(posedge clk); #1;
        gnt_val = 1'b1;
        wait_accept(50);
        wait_done(50);
        chk("bp_w0", wlog.size() > 0 ? wlog[0] : 32'hx, 32'h10111111);
        chk("bp_w1", wlog.size() > 1 ? wlog[1] : 32'hx, 32'h20222222);
        chk("bp_w2", wlog.size() > 2 ? wlog[2] : 32'hx, 32'h30333333);
        chk("bp_count", count, 9'd3);

        // Explicit op=11 beat
        pulse_start();
        send(4'hE, 2'b11, 6'b000000, 4'd1, 4'd2, 12'h003, 24'd0, 1'b1);
        wait_done(50);
        chk("ill_count", count, ILL ? 9'd0 : 9'd1);
        chk("ill_err", err, ILL);
        chk("ill_word", wlog.size() > 0 ? wlog[0] : 32'h0, ILL ? 32'h0 : 32'hEC012003);

        // Random stream with random grants
        gnt_rand = 1'b1;
        npush = 0;
        any_ill = 1'b0;
        pulse_start();
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            if (!(ILL && o == 2'b11)) npush++;
            if (o == 2'b11) any_ill = 1'b1;
            send_rand(o, i == 23);
        end
        wait_done(200);
        gnt_rand = 1'b0;
        chk("rnd_count", count, npush);
        chk("rnd_writes", writes, npush);
        chk("rnd_err", err, ILL && any_ill);

        // Address overflow
        @(posedge clk); #1;
        pulse_start();
        for (int i = 0; i < 257; i++) begin
            if (busy) send_rand(2'($urandom_range(0, 2)), i == 256);
        end
        wait_done(50);
        chk("ovf_writes", writes, 256);
        chk("ovf_count", count, 9'd256);
        chk("ovf_err", err, 1'b1);
        chk("ovf_addr", mem_addr, 8'd0);
        chk("ovf_last_word_addr", exp_addr, 0);

        // Reset while two words are queued
        gnt_val = 1'b0;
        @(posedge clk); #1;
        pulse_start();
        send_rand(2'b00, 1'b0);
        send_rand(2'b01, 1'b0);
        chk("mid_queued", mem_we, 1'b1);
        mon_en = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        expq.delete();
        chk("mid_we", mem_we, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_count", count, 9'd0);
        chk("mid_in_ready", in_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_we_next", mem_we, 1'b0);
        chk("mid_done", done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
